decimal_to_binary: RTL

Sequential decoder that converts three 7-segment digit codes (hundreds, tens, ones) back into a 10-bit binary value. It is the inverse of the existing score encoder Binary_to_Decimal. It is used to read back a score or setting entered or shown as digits, for example by challenge-mode score entry and by the adjustment menu. It processes one digit per clock with a start/busy/done handshake and flags invalid codes.

---
 rtl/decimal_to_binary.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/decimal_to_binary.sv
// Sequential 7-segment to binary decoder: converts hundreds/tens/ones segment
// codes into a binary score, one digit per clock, and flags illegal codes.
module decimal_to_binary #(
  parameter int DIGITS = 3,
  parameter int OUT_W  = 10
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [8*DIGITS-1:0]   character,
  output logic                  busy,
  output logic                  done,
  output logic [OUT_W-1:0]      scores,
  output logic                  error
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_HUNS,
    S_TENS,
    S_ONES
  } state_e;

  typedef struct packed {
    logic       legal;
    logic       blank;
    logic [3:0] value;
  } digit_t;

  state_e              state_q,  state_d;
  logic [8*DIGITS-1:0] char_q,   char_d;
  logic [OUT_W-1:0]    acc_q,    acc_d;
  logic                ill_q,    ill_d;
  logic                busy_q,   busy_d;
  logic                done_q,   done_d;
  logic [OUT_W-1:0]    scores_q, scores_d;
  logic                error_q,  error_d;

  // Bit 0 carries the decimal point, so it never takes part in the decode.
  function automatic digit_t seg_decode(input logic [7:0] code);
    digit_t d;
    d.legal = 1'b1;
    d.blank = 1'b0;
    d.value = 4'd0;
    unique case ({code[7:1], 1'b0})
      8'hFC:   d.value = 4'd0;
      8'h60:   d.value = 4'd1;
      8'hDA:   d.value = 4'd2;
      8'hF2:   d.value = 4'd3;
      8'h66:   d.value = 4'd4;
      8'hB6:   d.value = 4'd5;
      8'hBE:   d.value = 4'd6;
      8'hE0:   d.value = 4'd7;
      8'hFE:   d.value = 4'd8;
      8'hF6:   d.value = 4'd9;
      8'h00: begin
        d.blank = 1'b1;
        d.legal = 1'b0;
      end
      default: d.legal = 1'b0;
    endcase
    return d;
  endfunction

  // Multiply by ten with two shifts and an add.
  function automatic logic [OUT_W-1:0] times_ten(input logic [OUT_W-1:0] a);
    return (a << 3) + (a << 1);
  endfunction

  digit_t dig_h, dig_t, dig_o;
  logic   legal_h, legal_t, legal_o;

  always_comb begin
    dig_h = seg_decode(char_q[23:16]);
    dig_t = seg_decode(char_q[15:8]);
    dig_o = seg_decode(char_q[7:0]);
    // A blank digit is only a zero while it is leading; the ones digit never is.
    legal_h = dig_h.legal | dig_h.blank;
    legal_t = dig_t.legal | (dig_t.blank & dig_h.blank);
    legal_o = dig_o.legal;
  end

  // NOTE: every always_comb target gets a default first so no latch is inferred.
  always_comb begin
    state_d  = state_q;
    char_d   = char_q;
    acc_d    = acc_q;
    ill_d    = ill_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    scores_d = scores_q;
    error_d  = error_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          char_d  = character;
          acc_d   = '0;
          ill_d   = 1'b0;
          busy_d  = 1'b1;
          state_d = S_HUNS;
        end
      end
      S_HUNS: begin
        acc_d   = OUT_W'(dig_h.value);
        ill_d   = ill_q | ~legal_h;
        state_d = S_TENS;
      end
      S_TENS: begin
        acc_d   = times_ten(acc_q) + OUT_W'(dig_t.value);
        ill_d   = ill_q | ~legal_t;
        state_d = S_ONES;
      end
      S_ONES: begin
        acc_d    = times_ten(acc_q) + OUT_W'(dig_o.value);
        ill_d    = ill_q | ~legal_o;
        scores_d = ill_d ? '0 : acc_d;
        error_d  = ill_d;
        done_d   = 1'b1;
        busy_d   = 1'b0;
        state_d  = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments; reset is synchronous
  // and clears every register, including the captured character.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      char_q   <= '0;
      acc_q    <= '0;
      ill_q    <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      scores_q <= '0;
      error_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      char_q   <= char_d;
      acc_q    <= acc_d;
      ill_q    <= ill_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      scores_q <= scores_d;
      error_q  <= error_d;
    end
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign scores = scores_q;
  assign error  = error_q;

endmodule
